// File: rtl/spi_master_io.sv
// spi_master_io: SPI master shift engine and pin driver.
//
// Pops bytes from a first-word-fall-through TX FIFO and serialises them on
// sclk/mosi while ss is low. Samples miso into a byte register. Each completed
// byte is shifted into a 64-bit accumulator. rx_access pulses for one cycle
// when the transaction ends.
//
// Ports:
//   clk, reset      core clock; synchronous active-high reset
//   spi_en          start/continue permission for new bytes
//   cpol, cpha      SPI mode (sclk idle level, sample edge)
//   lsbfirst        1: bit0 is sent and received first
//   clkdiv_reg      sclk half-period is clkdiv_reg+1 clk cycles
//   fifo_dout       TX FIFO head
//   fifo_empty      TX FIFO empty
//   fifo_read       pop strobe (combinational)
//   spi_state       FSM state: 00 IDLE, 01 SETUP, 10 DATA, 11 HOLD
//   rx_data         last 8 received bytes; newest byte in [7:0]
//   rx_access       one-cycle pulse at end of transaction
//   sclk, mosi, ss  registered SPI pins (ss active low)
//   miso            serial data in
module spi_master_io (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_en,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        lsbfirst,
  input  logic [7:0]  clkdiv_reg,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_read,
  output logic [1:0]  spi_state,
  output logic [63:0] rx_data,
  output logic        rx_access,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  input  logic        miso
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_DATA  = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hc_q, hc_d;       // half-period counter
  logic [7:0]  div_q, div_d;     // divider captured at each reload
  logic [3:0]  tc_q, tc_d;       // tick index within the current byte (0..15)
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_access_q, rx_access_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;

  logic        tick;
  logic        can_pop;
  logic        pop;
  logic        leading;
  logic        do_sample;
  logic        do_shift;
  logic [7:0]  byte_done;

  // FIFO handshake: fifo_empty low means fifo_dout is valid; fifo_read is the
  // ready/pop strobe and the byte is consumed in the same cycle it is high.
  assign can_pop = spi_en & ~fifo_empty;
  assign tick    = (state_q != ST_IDLE) && (hc_q == div_q);

  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    div_d       = div_q;
    tc_d        = tc_q;
    tx_sh_d     = tx_sh_q;
    rx_byte_d   = rx_byte_q;
    rx_data_d   = rx_data_q;
    rx_access_d = 1'b0;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    pop         = 1'b0;
    leading     = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    byte_done   = 8'd0;

    // Divider is re-read on every reload so a change lands at the next
    // half-period boundary.
    if (state_q == ST_IDLE) begin
      hc_d  = 8'd0;
      div_d = clkdiv_reg;
    end else if (tick) begin
      hc_d  = 8'd0;
      div_d = clkdiv_reg;
    end else begin
      hc_d  = hc_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        ss_d   = 1'b1;
        sclk_d = cpol;
        if (can_pop) begin
          pop       = 1'b1;
          tx_sh_d   = fifo_dout;
          tc_d      = 4'd0;
          rx_byte_d = 8'd0;
          ss_d      = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ss_d   = 1'b0;
        sclk_d = cpol;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          sclk_d  = ~sclk_q;
          tc_d    = tc_q + 4'd1;
          // Ticks 1,3,..,15 (tc even) are leading edges.
          leading = ~tc_q[0];
          if (cpha) begin
            do_sample = ~leading;
            // First bit is already on mosi from SETUP / byte boundary.
            do_shift  = leading && (tc_q != 4'd0);
          end else begin
            do_sample = leading;
            do_shift  = ~leading;
          end
          if (do_sample)
            rx_byte_d = lsbfirst ? {miso, rx_byte_q[7:1]} : {rx_byte_q[6:0], miso};
          if (do_shift)
            tx_sh_d = lsbfirst ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
          if (tc_q == 4'd15) begin
            byte_done = rx_byte_d;
            rx_data_d = {rx_data_q[55:0], byte_done};
            if (can_pop) begin
              pop       = 1'b1;
              tx_sh_d   = fifo_dout;
              rx_byte_d = 8'd0;
            end else begin
              state_d   = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        sclk_d = cpol;
        if (tick) begin
          state_d     = ST_IDLE;
          ss_d        = 1'b1;
          rx_access_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mosi_d = (state_d == ST_IDLE) ? 1'b0 : (lsbfirst ? tx_sh_d[0] : tx_sh_d[7]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hc_q        <= 8'd0;
      div_q       <= 8'd0;
      tc_q        <= 4'd0;
      tx_sh_q     <= 8'd0;
      rx_byte_q   <= 8'd0;
      rx_data_q   <= 64'd0;
      rx_access_q <= 1'b0;
      sclk_q      <= cpol;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      div_q       <= div_d;
      tc_q        <= tc_d;
      tx_sh_q     <= tx_sh_d;
      rx_byte_q   <= rx_byte_d;
      rx_data_q   <= rx_data_d;
      rx_access_q <= rx_access_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
    end
  end

  assign fifo_read = pop & ~reset;
  assign spi_state = state_q;
  assign rx_data   = rx_data_q;
  assign rx_access = rx_access_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss        = ss_q;

endmodule
